// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package rc4_pkg;

    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_KEY_BYTES = 3;
    localparam int unsigned KEY_MAX_BYTES = 32;
    localparam int unsigned KEY_MAX_W     = 8 * KEY_MAX_BYTES;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        WAIT_I,
        GET_I,
        RD_J,
        WAIT_J,
        GET_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

    // Byte k of an nbytes-long key, where byte 0 sits in the most significant position.
    function automatic logic [7:0] key_byte(input logic [KEY_MAX_W-1:0] key,
                                            input int unsigned           nbytes,
                                            input int unsigned           k);
        logic [KEY_MAX_W-1:0] shifted;
        shifted = key >> (8 * (nbytes - 1 - k));
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/rc4_ksa_core_if.sv
// Control handshake and single-port S memory bus of the RC4 key-scheduling engine.
interface rc4_ksa_core_if
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned KEY_BYTES = DEF_KEY_BYTES
);

    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic [ADDR_W-1:0]      s_addr;
    logic [ADDR_W-1:0]      s_wdata;
    logic                   s_wren;
    logic [ADDR_W-1:0]      s_rdata;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, secret_key, s_rdata,
        output s_addr, s_wdata, s_wren, busy, done
    );

    modport slave (
        output start, secret_key, s_rdata,
        input  s_addr, s_wdata, s_wren, busy, done
    );

endinterface

// File: rtl/rc4_ksa_core.sv
// RC4 key scheduling: fills S with the identity permutation, then runs the
// key-driven swap loop against an external single-port memory.
module rc4_ksa_core
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned KEY_BYTES = DEF_KEY_BYTES,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    rc4_ksa_core_if.master bus
);

    localparam int unsigned KEY_W     = 8 * KEY_BYTES;
    localparam int unsigned K_W       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned WAIT_W    = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
    localparam int unsigned WAIT_LOAD = (READ_LAT > 1) ? READ_LAT - 2 : 0;

    localparam logic [ADDR_W-1:0] I_LAST = '1;
    localparam logic [K_W-1:0]    K_LAST = K_W'(KEY_BYTES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [ADDR_W-1:0]   si_q, si_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [ADDR_W-1:0]   s_wdata_q, s_wdata_d;
    logic                s_wren_q, s_wren_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [ADDR_W-1:0]   key_add_c;
    logic [ADDR_W-1:0]   j_sum_c;

    // Key byte for the current step, truncated or widened to the S element width.
    assign key_add_c = ADDR_W'(key_byte(KEY_MAX_W'(key_q), KEY_BYTES, 32'(k_q)));
    assign j_sum_c   = j_q + bus.s_rdata + key_add_c;

    // Next-state logic; memory-side outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        wait_d    = wait_q;
        key_d     = key_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wren_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = INIT;
                    key_d     = bus.secret_key;
                    i_d       = '0;
                    busy_d    = 1'b1;
                    s_addr_d  = '0;
                    s_wdata_d = '0;
                    s_wren_d  = 1'b1;
                end
            end
            INIT: begin
                if (i_q == I_LAST) begin
                    state_d  = RD_I;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    s_addr_d = '0;
                end else begin
                    i_d       = i_q + ADDR_W'(1);
                    s_addr_d  = i_q + ADDR_W'(1);
                    s_wdata_d = i_q + ADDR_W'(1);
                    s_wren_d  = 1'b1;
                end
            end
            RD_I: begin
                state_d = (READ_LAT > 1) ? WAIT_I : GET_I;
                wait_d  = WAIT_W'(WAIT_LOAD);
            end
            WAIT_I: begin
                if (wait_q == '0) state_d = GET_I;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            GET_I: begin
                si_d     = bus.s_rdata;
                j_d      = j_sum_c;
                state_d  = RD_J;
                s_addr_d = j_sum_c;
            end
            RD_J: begin
                state_d = (READ_LAT > 1) ? WAIT_J : GET_J;
                wait_d  = WAIT_W'(WAIT_LOAD);
            end
            WAIT_J: begin
                if (wait_q == '0) state_d = GET_J;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            GET_J: begin
                state_d   = WR_I;
                s_addr_d  = i_q;
                s_wdata_d = bus.s_rdata;
                s_wren_d  = 1'b1;
            end
            WR_I: begin
                state_d   = WR_J;
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
            end
            WR_J: begin
                if (i_q == I_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = RD_I;
                    i_d      = i_q + ADDR_W'(1);
                    k_d      = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
                    s_addr_d = i_q + ADDR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            si_q      <= '0;
            wait_q    <= '0;
            key_q     <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wren_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            si_q      <= si_d;
            wait_q    <= wait_d;
            key_q     <= key_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wren_q  <= s_wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wren  = s_wren_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
